// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a framed byte stream and assembles little-endian 32-bit words. Each word is written to
// consecutive instruction-memory addresses. The core is held in reset until a complete,
// checksum-valid program has been written.
//
// Frame: MAGIC, COUNT_LO, COUNT_HI, COUNT x 4 data bytes, CHECK (XOR of count and data bytes).
//
// Ports:
//   clock_i       clock
//   reset_n_i     asynchronous active-low reset
//   rx_data_i     received byte
//   rx_valid_i    one-cycle strobe qualifying rx_data_i
//   wr_enable_o   instruction-memory write strobe (one cycle per word)
//   wr_addr_o     write byte address, held until the next write
//   wr_data_o     write word, held until the next write
//   core_reset_o  active-high core reset, low only once a program is loaded and verified
//   done_o        program loaded and verified
//   error_o       frame rejected (oversized count, bad checksum or inter-byte timeout)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned MAX_WORDS      = 256,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        wr_enable_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        core_reset_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e      state_q;
    logic [15:0] count_q;
    logic [15:0] index_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;     // first three bytes of the word in flight, oldest in [7:0]
    logic [7:0]  xor_q;
    logic [31:0] timer_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= StIdle;
            count_q      <= 16'd0;
            index_q      <= 16'd0;
            byte_cnt_q   <= 2'd0;
            shift_q      <= 24'd0;
            xor_q        <= 8'd0;
            timer_q      <= 32'd0;
            wr_enable_o  <= 1'b0;
            wr_addr_o    <= BASE_ADDR;
            wr_data_o    <= 32'd0;
            core_reset_o <= 1'b1;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            wr_enable_o <= 1'b0;

            case (state_q)
                StIdle, StDone, StError: begin
                    // MAGIC starts a fresh load from any resting state.
                    if (rx_valid_i && rx_data_i == MAGIC) begin
                        index_q      <= 16'd0;
                        xor_q        <= 8'd0;
                        byte_cnt_q   <= 2'd0;
                        core_reset_o <= 1'b1;
                        done_o       <= 1'b0;
                        error_o      <= 1'b0;
                        state_q      <= StCntLo;
                    end
                end
                StCntLo: begin
                    if (rx_valid_i) begin
                        count_q[7:0] <= rx_data_i;
                        xor_q        <= xor_q ^ rx_data_i;
                        state_q      <= StCntHi;
                    end
                end
                StCntHi: begin
                    if (rx_valid_i) begin
                        count_q[15:8] <= rx_data_i;
                        xor_q         <= xor_q ^ rx_data_i;
                        if ({16'd0, rx_data_i, count_q[7:0]} > MAX_WORDS) begin
                            error_o <= 1'b1;
                            state_q <= StError;
                        end else if ({rx_data_i, count_q[7:0]} == 16'd0) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (rx_valid_i) begin
                        xor_q <= xor_q ^ rx_data_i;
                        if (byte_cnt_q == 2'd3) begin
                            wr_enable_o <= 1'b1;
                            wr_addr_o   <= BASE_ADDR + {14'd0, index_q, 2'b00};
                            wr_data_o   <= {rx_data_i, shift_q};
                            index_q     <= index_q + 16'd1;
                            byte_cnt_q  <= 2'd0;
                            if (index_q + 16'd1 == count_q) begin
                                state_q <= StCheck;
                            end
                        end else begin
                            shift_q    <= {rx_data_i, shift_q[23:8]};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                StCheck: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == xor_q) begin
                            done_o       <= 1'b1;
                            core_reset_o <= 1'b0;
                            state_q      <= StDone;
                        end else begin
                            error_o <= 1'b1;
                            state_q <= StError;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Inter-byte timeout: counts idle edges while inside a frame. No byte is accepted
            // on an idle edge, so this never competes with the byte handling above.
            if (state_q == StCntLo || state_q == StCntHi || state_q == StData ||
                state_q == StCheck) begin
                if (rx_valid_i) begin
                    timer_q <= 32'd0;
                end else if (timer_q == TIMEOUT_CYCLES - 1) begin
                    timer_q <= 32'd0;
                    error_o <= 1'b1;
                    state_q <= StError;
                end else begin
                    timer_q <= timer_q + 32'd1;
                end
            end else begin
                timer_q <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances share the stimulus. They differ only in base address
// (0x0 and 0x100), and both use a 10-cycle timeout. Expected writes and status are derived from
// the frame contents built here.
module tb_imem_loader;

    localparam logic [31:0] Base0 = 32'h0000_0000;
    localparam logic [31:0] Base1 = 32'h0000_0100;
    localparam int unsigned Tmo   = 10;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wen0, wen1;
    logic [31:0] addr0, addr1, data0, data1;
    logic        crst0, crst1, done0, done1, err0, err1;

    imem_loader #(
        .BASE_ADDR      (Base0),
        .MAGIC          (8'hA5),
        .MAX_WORDS      (256),
        .TIMEOUT_CYCLES (Tmo)
    ) dut0 (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .wr_enable_o  (wen0),
        .wr_addr_o    (addr0),
        .wr_data_o    (data0),
        .core_reset_o (crst0),
        .done_o       (done0),
        .error_o      (err0)
    );

    imem_loader #(
        .BASE_ADDR      (Base1),
        .MAGIC          (8'hA5),
        .MAX_WORDS      (256),
        .TIMEOUT_CYCLES (Tmo)
    ) dut1 (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .wr_enable_o  (wen1),
        .wr_addr_o    (addr1),
        .wr_data_o    (data1),
        .core_reset_o (crst1),
        .done_o       (done1),
        .error_o      (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;

    // Count strobe cycles; a strobe longer than one cycle shows up as an extra write.
    always @(negedge clk) begin
        if (wen0) wr_cnt0 <= wr_cnt0 + 1;
        if (wen1) wr_cnt1 <= wr_cnt1 + 1;
    end

    logic [7:0]  fr[$];
    logic [31:0] exp_words[$];
    int          hdr;
    int          gap_idx = -1;
    int          gap_len = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, ".wen0"}, 32'(wen0), 32'd0);
        check_eq({tag, ".addr0"}, addr0, Base0);
        check_eq({tag, ".data0"}, data0, 32'd0);
        check_eq({tag, ".crst0"}, 32'(crst0), 32'd1);
        check_eq({tag, ".done0"}, 32'(done0), 32'd0);
        check_eq({tag, ".err0"}, 32'(err0), 32'd0);
        check_eq({tag, ".wen1"}, 32'(wen1), 32'd0);
        check_eq({tag, ".addr1"}, addr1, Base1);
        check_eq({tag, ".data1"}, data1, 32'd0);
        check_eq({tag, ".crst1"}, 32'(crst1), 32'd1);
        check_eq({tag, ".done1"}, 32'(done1), 32'd0);
        check_eq({tag, ".err1"}, 32'(err1), 32'd0);
    endtask

    task automatic check_status(input string tag, input bit ok);
        check_eq({tag, ".done0"}, 32'(done0), 32'(ok));
        check_eq({tag, ".err0"}, 32'(err0), 32'(!ok));
        check_eq({tag, ".crst0"}, 32'(crst0), 32'(!ok));
        check_eq({tag, ".done1"}, 32'(done1), 32'(ok));
        check_eq({tag, ".err1"}, 32'(err1), 32'(!ok));
        check_eq({tag, ".crst1"}, 32'(crst1), 32'(!ok));
    endtask

    // Wait gap idle edges, then present one byte for one edge; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Reference model: frame = junk, MAGIC, count (LE), words (LE bytes), XOR checksum.
    task automatic build_frame(input int n, input int junk, input bit corrupt);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [31:0] w;
        fr.delete();
        exp_words.delete();
        for (int i = 0; i < junk; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            fr.push_back(b);
        end
        hdr = fr.size();
        fr.push_back(8'hA5);
        fr.push_back(8'(n));
        fr.push_back(8'(n >> 8));
        chk = 8'(n) ^ 8'(n >> 8);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int j = 0; j < 4; j++) begin
                b = 8'(w >> (8 * j));
                fr.push_back(b);
                chk = chk ^ b;
            end
        end
        if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
        fr.push_back(chk);
    endtask

    // Send fr; check every write right after its 4th byte, then write count and final status.
    task automatic run_frame(input string tag, input bit exp_ok, input int max_gap);
        int n, c0, c1, g, k, rel;
        n  = exp_words.size();
        c0 = wr_cnt0;
        c1 = wr_cnt1;
        for (int i = 0; i < fr.size(); i++) begin
            g = (i == gap_idx) ? gap_len : int'($urandom_range(0, max_gap));
            send_byte(fr[i], g);
            rel = i - hdr - 3;
            if (rel >= 0 && rel < 4 * n && rel % 4 == 3) begin
                k = rel / 4;
                check_eq($sformatf("%s.wen0[%0d]", tag, k), 32'(wen0), 32'd1);
                check_eq($sformatf("%s.addr0[%0d]", tag, k), addr0, Base0 + 32'(4 * k));
                check_eq($sformatf("%s.data0[%0d]", tag, k), data0, exp_words[k]);
                check_eq($sformatf("%s.wen1[%0d]", tag, k), 32'(wen1), 32'd1);
                check_eq($sformatf("%s.addr1[%0d]", tag, k), addr1, Base1 + 32'(4 * k));
                check_eq($sformatf("%s.data1[%0d]", tag, k), data1, exp_words[k]);
            end
        end
        check_status(tag, exp_ok);
        @(negedge clk);
        check_eq({tag, ".nwr0"}, 32'(wr_cnt0 - c0), 32'(n));
        check_eq({tag, ".nwr1"}, 32'(wr_cnt1 - c1), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #22;
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Junk before MAGIC is ignored; empty program verifies.
        fr = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00};
        exp_words.delete();
        hdr = 3;
        run_frame("junk", 1'b1, 0);

        // Directed two-word program, back-to-back.
        fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00,
               8'h63, 8'h00, 8'h00, 8'h00, 8'hD7};
        exp_words = '{32'h00A00513, 32'h00000063};
        hdr = 0;
        run_frame("prog", 1'b1, 0);

        // Same program with a bad checksum: writes stay, frame rejected.
        fr[11] = 8'hD6;
        run_frame("badchk", 1'b0, 0);
        fr[11] = 8'hD7;
        run_frame("reload", 1'b1, 0);

        // Count of MAX_WORDS+1 is rejected right after COUNT_HI.
        fr = '{8'hA5, 8'h01, 8'h01};
        exp_words.delete();
        hdr = 0;
        run_frame("oversize", 1'b0, 0);

        // Timeout: stall after the 2nd data byte of a one-word frame.
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        c0 = wr_cnt0;
        repeat (Tmo - 1) begin
            @(posedge clk);
            #1;
        end
        check_eq("tmo.early.err0", 32'(err0), 32'd0);
        check_eq("tmo.early.err1", 32'(err1), 32'd0);
        @(posedge clk);
        #1;
        check_status("tmo", 1'b0);
        check_eq("tmo.nwr0", 32'(wr_cnt0 - c0), 32'd0);

        // A stall one cycle shorter than the timeout is tolerated.
        build_frame(1, 0, 1'b0);
        gap_idx = hdr + 5;
        gap_len = int'(Tmo) - 1;
        run_frame("stall9", 1'b1, 0);
        gap_idx = -1;

        // Asynchronous reset mid-DATA.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        build_frame(2, 0, 1'b0);
        run_frame("afterrst", 1'b1, 0);

        // Randomized frames with junk, gaps below the timeout and occasional bad checksums.
        for (int f = 0; f < 20; f++) begin
            bit corrupt;
            corrupt = ($urandom_range(0, 3) == 0);
            build_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), corrupt);
            run_frame($sformatf("rnd%0d", f), !corrupt, int'($urandom_range(0, Tmo - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
